// File: rtl/nibbler_pkg.sv
// Shared definitions for the NibblER core: ALU opcodes, instruction set,
// sequencer states, operand-select codes and instruction-word helpers.
package nibbler_pkg;

  localparam logic [2:0] ALU_OUT = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b001;
  localparam logic [2:0] ALU_LD  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;

  typedef enum logic [3:0] {
    OP_LIT  = 4'h0, OP_IN   = 4'h1, OP_LD   = 4'h2, OP_ST   = 4'h3,
    OP_OUT  = 4'h4, OP_CMPI = 4'h5, OP_CMPM = 4'h6, OP_ADDI = 4'h7,
    OP_ADDM = 4'h8, OP_NORI = 4'h9, OP_NORM = 4'hA, OP_JMP  = 4'hB,
    OP_JC   = 4'hC, OP_JNC  = 4'hD, OP_JZ   = 4'hE, OP_JNZ  = 4'hF
  } instr_op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_MEM    = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

  // Source of the ALU B operand during EXEC
  typedef enum logic [1:0] {
    B_ZERO = 2'd0,
    B_IMM  = 2'd1,
    B_IN   = 2'd2,
    B_MDR  = 2'd3
  } bsel_e;

  function automatic instr_op_e ir_op(input logic [11:0] w);
    return instr_op_e'(w[11:8]);
  endfunction

  function automatic logic [7:0] ir_operand(input logic [11:0] w);
    return w[7:0];
  endfunction

  function automatic logic [3:0] ir_imm(input logic [11:0] w);
    return w[3:0];
  endfunction

  // Conditional-branch evaluation against the current flags
  function automatic logic jump_taken(input instr_op_e op, input logic c, input logic z);
    case (op)
      OP_JMP:  return 1'b1;
      OP_JC:   return c;
      OP_JNC:  return ~c;
      OP_JZ:   return z;
      OP_JNZ:  return ~z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational instruction decoder: opcode -> ALU control and sequencing hints.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  instr_op_e  op,
  output logic [2:0] alu_opcode,
  output bsel_e      b_sel,
  output logic       is_mem,
  output logic       is_write,
  output logic       is_jump,
  output logic       writes_a,
  output logic       writes_flags
);

  // Map each instruction to its ALU operation, B source and side effects
  always_comb begin
    alu_opcode   = ALU_OUT;
    b_sel        = B_ZERO;
    is_mem       = 1'b0;
    is_write     = 1'b0;
    is_jump      = 1'b0;
    writes_a     = 1'b0;
    writes_flags = 1'b0;
    case (op)
      OP_LIT:  begin alu_opcode = ALU_LD;  b_sel = B_IMM; writes_a = 1'b1; writes_flags = 1'b1; end
      OP_IN:   begin alu_opcode = ALU_LD;  b_sel = B_IN;  writes_a = 1'b1; writes_flags = 1'b1; end
      OP_LD:   begin alu_opcode = ALU_LD;  b_sel = B_MDR; is_mem = 1'b1; writes_a = 1'b1; writes_flags = 1'b1; end
      OP_ST:   begin is_mem = 1'b1; is_write = 1'b1; end
      OP_OUT:  begin alu_opcode = ALU_OUT; b_sel = B_ZERO; end
      OP_CMPI: begin alu_opcode = ALU_CMP; b_sel = B_IMM; writes_flags = 1'b1; end
      OP_CMPM: begin alu_opcode = ALU_CMP; b_sel = B_MDR; is_mem = 1'b1; writes_flags = 1'b1; end
      OP_ADDI: begin alu_opcode = ALU_ADD; b_sel = B_IMM; writes_a = 1'b1; writes_flags = 1'b1; end
      OP_ADDM: begin alu_opcode = ALU_ADD; b_sel = B_MDR; is_mem = 1'b1; writes_a = 1'b1; writes_flags = 1'b1; end
      OP_NORI: begin alu_opcode = ALU_NOR; b_sel = B_IMM; writes_a = 1'b1; writes_flags = 1'b1; end
      OP_NORM: begin alu_opcode = ALU_NOR; b_sel = B_MDR; is_mem = 1'b1; writes_a = 1'b1; writes_flags = 1'b1; end
      default: is_jump = 1'b1;
    endcase
  end

endmodule

// File: rtl/nibbler_ctrl.sv
// NibblER sequencer: fetch/decode/{mem}/exec FSM owning PC, A, C/Z, MDR and output port.
module nibbler_ctrl
  import nibbler_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [11:0]     rom_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [7:0]      mem_addr,
  output logic [3:0]      mem_wdata,
  input  logic [3:0]      mem_rdata,
  input  logic            mem_ack,
  input  logic [3:0]      in_data,
  output logic [3:0]      out_data,
  output logic            out_strobe,
  output logic [2:0]      alu_opcode,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_out,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic [3:0]      acc,
  output logic            flag_c,
  output logic            flag_z
);

  state_e          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [3:0]      acc_reg;
  logic            c_reg;
  logic            z_reg;
  logic [11:0]     ir_reg;
  logic [3:0]      mdr_reg;
  logic [3:0]      out_data_reg;
  logic            out_strobe_reg;
  logic            mem_req_reg;

  logic [PC_W-1:0] pc_next_seq;
  logic [11:0]     dec_word;
  logic [7:0]      dec_operand;
  logic [2:0]      dec_alu_opcode;
  bsel_e           dec_b_sel;
  logic            dec_is_mem;
  logic            dec_is_write;
  logic            dec_is_jump;
  logic            dec_writes_a;
  logic            dec_writes_flags;

  // In DECODE the fresh ROM word is decoded directly; afterwards the latched IR
  assign dec_word    = (state_reg == ST_DECODE) ? rom_data : ir_reg;
  assign dec_operand = ir_operand(dec_word);
  assign pc_next_seq = pc_reg + PC_W'(1);

  nibbler_decode u_decode (
    .op           (ir_op(dec_word)),
    .alu_opcode   (dec_alu_opcode),
    .b_sel        (dec_b_sel),
    .is_mem       (dec_is_mem),
    .is_write     (dec_is_write),
    .is_jump      (dec_is_jump),
    .writes_a     (dec_writes_a),
    .writes_flags (dec_writes_flags)
  );

  assign rom_addr   = pc_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_req_reg && (ir_op(ir_reg) == OP_ST);
  assign mem_addr   = ir_operand(ir_reg);
  assign mem_wdata  = acc_reg;
  assign out_data   = out_data_reg;
  assign out_strobe = out_strobe_reg;
  assign alu_a      = acc_reg;
  assign acc        = acc_reg;
  assign flag_c     = c_reg;
  assign flag_z     = z_reg;

  // ALU control is live only during EXEC; idle as OUT with a zero B operand
  always_comb begin
    alu_opcode = ALU_OUT;
    alu_b      = 4'h0;
    if (state_reg == ST_EXEC) begin
      alu_opcode = dec_alu_opcode;
      case (dec_b_sel)
        B_IMM:   alu_b = ir_imm(ir_reg);
        B_IN:    alu_b = in_data;
        B_MDR:   alu_b = mdr_reg;
        default: alu_b = 4'h0;
      endcase
    end
  end

  // Sequencer FSM with architectural state updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      acc_reg        <= 4'h0;
      c_reg          <= 1'b0;
      z_reg          <= 1'b0;
      ir_reg         <= 12'h000;
      mdr_reg        <= 4'h0;
      out_data_reg   <= 4'h0;
      out_strobe_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
    end else begin
      out_strobe_reg <= 1'b0;
      case (state_reg)
        ST_FETCH: begin
          if (run) state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_reg <= rom_data;
          if (dec_is_jump) begin
            pc_reg    <= jump_taken(ir_op(dec_word), c_reg, z_reg) ? dec_operand[PC_W-1:0]
                                                                   : pc_next_seq;
            state_reg <= ST_FETCH;
          end else begin
            pc_reg <= pc_next_seq;
            if (dec_is_mem) begin
              state_reg   <= ST_MEM;
              mem_req_reg <= 1'b1;
            end else begin
              state_reg <= ST_EXEC;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack && mem_req_reg) begin
            mem_req_reg <= 1'b0;
            if (dec_is_write) begin
              state_reg <= ST_FETCH;
            end else begin
              mdr_reg   <= mem_rdata;
              state_reg <= ST_EXEC;
            end
          end
        end
        default: begin
          if (dec_writes_a) acc_reg <= alu_out;
          if (dec_writes_flags) begin
            c_reg <= alu_carry;
            z_reg <= alu_zero;
          end
          if (ir_op(ir_reg) == OP_OUT) begin
            out_data_reg   <= acc_reg;
            out_strobe_reg <= 1'b1;
          end
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_ctrl.sv
// Directed bench for nibbler_ctrl with behavioural ROM, RAM and ALU around it.
module tb_nibbler_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  in_data = 4'h0;
  logic [3:0]  out_data;
  logic        out_strobe;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_out;
  logic        alu_carry;
  logic        alu_zero;
  logic [3:0]  acc;
  logic        flag_c;
  logic        flag_z;

  logic [11:0] rom [0:255];
  logic [3:0]  ram [0:255];
  logic [7:0]  wait_cnt = 8'h00;
  logic [7:0]  ack_delay = 8'h00;
  logic        ack_force = 1'b0;
  logic [4:0]  alu_tmp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibbler_ctrl dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .in_data(in_data), .out_data(out_data), .out_strobe(out_strobe),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z)
  );

  // Synchronous ROM: word valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  // RAM acknowledges after ack_delay waiting cycles; ack_force injects stray acks
  assign mem_ack   = (mem_req && (wait_cnt == ack_delay)) || ack_force;
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (!mem_req) wait_cnt <= 8'h00;
    else if (!mem_ack) wait_cnt <= wait_cnt + 8'h01;
    if (mem_req && mem_ack) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      $display("MEM %s addr=%02h data=%h", mem_we ? "WR" : "RD", mem_addr,
               mem_we ? mem_wdata : mem_rdata);
    end
    if (out_strobe) $display("OUT data=%h", out_data);
  end

  // Reference 4-bit ALU
  always_comb begin
    alu_tmp   = 5'h00;
    alu_out   = alu_a;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    case (alu_opcode)
      3'b001: begin
        alu_tmp   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out   = alu_tmp[3:0];
        alu_carry = alu_tmp[4];
        alu_zero  = (alu_tmp[3:0] == 4'h0);
      end
      3'b010: begin
        alu_out  = alu_b;
        alu_zero = (alu_b == 4'h0);
      end
      3'b011: begin
        alu_tmp   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = alu_tmp[3:0];
        alu_carry = alu_tmp[4];
        alu_zero  = (alu_tmp[3:0] == 4'h0);
      end
      3'b100: begin
        alu_out  = ~(alu_a | alu_b);
        alu_zero = (alu_out == 4'h0);
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) ram[i] = 4'h0;

    // LIT 9; ADDI 8
    clear_rom();
    rom[0] = 12'h009; rom[1] = 12'h708;
    run = 1'b1;
    reset = 1'b1;
    tick(2);
    check_eq("rst_acc", acc, 0);
    check_eq("rst_pc", rom_addr, 0);
    check_eq("rst_flags", {flag_c, flag_z}, 0);
    check_eq("rst_out", {out_data, out_strobe}, 0);
    check_eq("rst_req", mem_req, 0);
    reset = 1'b0;
    tick(6);
    check_eq("add_acc", acc, 4'h1);
    check_eq("add_c", flag_c, 1);
    check_eq("add_z", flag_z, 0);
    check_eq("add_pc", rom_addr, 8'h02);

    // LIT 5; CMPI 5; JZ 20 -> taken
    clear_rom();
    rom[0] = 12'h005; rom[1] = 12'h505; rom[2] = 12'hE20;
    do_reset();
    tick(8);
    check_eq("cmpeq_acc", acc, 4'h5);
    check_eq("cmpeq_flags", {flag_c, flag_z}, 2'b01);
    check_eq("jz_taken_pc", rom_addr, 8'h20);

    // LIT 5; CMPI 6; JZ 20 -> not taken
    rom[1] = 12'h506;
    do_reset();
    tick(8);
    check_eq("cmplt_flags", {flag_c, flag_z}, 2'b10);
    check_eq("jz_fall_pc", rom_addr, 8'h03);

    // LIT 7; ST 10 with three wait cycles
    clear_rom();
    rom[0] = 12'h007; rom[1] = 12'h310;
    ack_delay = 8'd3;
    do_reset();
    tick(5);
    check_eq("st_we", mem_we, 1);
    check_eq("st_wdata", mem_wdata, 4'h7);
    check_eq("st_addr", mem_addr, 8'h10);
    cnt = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      cnt++;
      tick(1);
    end
    check_eq("st_req_cycles", cnt, 4);
    check_eq("st_ram", ram[8'h10], 4'h7);
    check_eq("st_pc", rom_addr, 8'h02);

    // LIT C; ST 10; LIT 1; LD 10; OUT
    clear_rom();
    rom[0] = 12'h00C; rom[1] = 12'h310; rom[2] = 12'h001;
    rom[3] = 12'h210; rom[4] = 12'h400;
    ack_delay = 8'd0;
    do_reset();
    tick(13);
    check_eq("ld_acc", acc, 4'hC);
    check_eq("ld_flags", {flag_c, flag_z}, 2'b00);
    tick(2);
    check_eq("out_pre_strobe", out_strobe, 0);
    tick(1);
    check_eq("out_strobe", out_strobe, 1);
    check_eq("out_data", out_data, 4'hC);
    tick(1);
    check_eq("out_strobe_drop", out_strobe, 0);
    check_eq("out_hold", out_data, 4'hC);

    // JMP FF; LIT 3 at FF -> PC wraps to 00
    clear_rom();
    rom[0] = 12'hBFF; rom[255] = 12'h003;
    do_reset();
    tick(2);
    check_eq("jmp_pc", rom_addr, 8'hFF);
    tick(3);
    check_eq("wrap_pc", rom_addr, 8'h00);
    check_eq("wrap_acc", acc, 4'h3);

    // run dropped during ADDI 2: instruction finishes, then holds
    clear_rom();
    rom[0] = 12'h702; rom[1] = 12'h702;
    do_reset();
    tick(2);
    run = 1'b0;
    tick(6);
    check_eq("hold_acc", acc, 4'h2);
    check_eq("hold_pc", rom_addr, 8'h01);
    run = 1'b1;
    tick(3);
    check_eq("resume_acc", acc, 4'h4);
    check_eq("resume_pc", rom_addr, 8'h02);

    // LD 10 with a long wait, reset mid-MEM, stray ack afterwards
    clear_rom();
    rom[0] = 12'h00A; rom[1] = 12'h210;
    ack_delay = 8'd50;
    do_reset();
    tick(6);
    check_eq("mem_wait_req", mem_req, 1);
    check_eq("mem_wait_acc", acc, 4'hA);
    reset = 1'b1;
    #1;
    check_eq("async_req_drop", mem_req, 0);
    check_eq("async_acc", acc, 0);
    check_eq("async_pc", rom_addr, 0);
    tick(1);
    run = 1'b0;
    reset = 1'b0;
    ack_force = 1'b1;
    tick(2);
    ack_force = 1'b0;
    tick(1);
    check_eq("late_ack_req", mem_req, 0);
    check_eq("late_ack_acc", acc, 0);
    check_eq("late_ack_pc", rom_addr, 0);
    ack_delay = 8'd0;
    run = 1'b1;
    tick(3);
    check_eq("post_rst_lit", acc, 4'hA);
    tick(4);
    check_eq("post_rst_ld", acc, 4'hC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
